// File: rtl/dds_nco_multich.sv
// -----------------------------------------------------------------------------
// dds_nco_multich
//   Time-multiplexed multi-channel NCO. NUM_CH phase accumulators share one
//   quarter-wave cosine table. Each output cycle services one channel and
//   produces both cos and sin for it. Frequency and phase words are
//   double-buffered: LoadF/LoadP write a channel's shadow register, and
//   Commit moves every shadow into the active set at once. Sync realigns the
//   phase of all channels.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   Enable     : advances slot counter, accumulators and pipeline (0 = hold)
//   LoadF/LoadP: write FreqPhase into freq/phase shadow of channel ChSel
//   Commit     : copy all shadows to the active registers
//   Sync       : clear all accumulators and the slot counter
//   ChSel      : channel addressed by LoadF/LoadP (>= NUM_CH is ignored)
//   FreqPhase  : tuning word / phase offset (unsigned)
//   Cos_Out    : packed signed cos, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   Sin_Out    : packed signed sin, same packing
//   Out_Valid  : one-cycle strobe, slice Out_Ch was just updated
//   Out_Ch     : channel updated this cycle
//   io_oeb     : pad output enables, tied low
// -----------------------------------------------------------------------------
module dds_nco_multich #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int LUT_AW     = 8,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Enable,
    input  logic                         LoadF,
    input  logic                         LoadP,
    input  logic                         Commit,
    input  logic                         Sync,
    input  logic [CH_W-1:0]              ChSel,
    input  logic [ACC_WIDTH-1:0]         FreqPhase,
    output logic [NUM_CH*DATA_WIDTH-1:0] Cos_Out,
    output logic [NUM_CH*DATA_WIDTH-1:0] Sin_Out,
    output logic                         Out_Valid,
    output logic [CH_W-1:0]              Out_Ch,
    output logic [15:0]                  io_oeb
);

    localparam int N        = 1 << LUT_AW;
    localparam int FRAC_LSB = ACC_WIDTH - LUT_AW - 2;

    // Quarter-wave entry k = round(A*cos(pi/2*(k+0.5)/N)), A = 2^(DATA_WIDTH-1)-1.
    // Evaluated at elaboration with a Q60 fixed-point Taylor series so the
    // table needs no external image file. Partial sums may go negative; the
    // modular 128-bit arithmetic still lands on the correct positive result.
    function automatic logic [DATA_WIDTH-1:0] lut_entry(input int k);
        logic [127:0] x, x2, term, sum, amp, prod;
        x    = (128'h3243F6A8885A308D * 128'(2 * k + 1)) / 128'(4 * N);
        x2   = (x * x) >> 60;
        term = 128'(1) << 60;
        sum  = term;
        for (int n = 1; n <= 20; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n - 1) * (2 * n));
            if (n % 2 == 1) sum = sum - term;
            else            sum = sum + term;
        end
        amp  = (128'(1) << (DATA_WIDTH - 1)) - 128'(1);
        prod = (amp * sum + (128'(1) << 59)) >> 60;
        return DATA_WIDTH'(prod);
    endfunction

    // Quadrant reconstruction from L[idx] (a) and L[~idx] (b). |L| <= A, so
    // negation cannot overflow.
    function automatic logic signed [DATA_WIDTH-1:0] cos_val(
        input logic [1:0] q, input logic signed [DATA_WIDTH-1:0] a, b);
        logic signed [DATA_WIDTH-1:0] r;
        case (q)
            2'd0:    r = a;
            2'd1:    r = -b;
            2'd2:    r = -a;
            default: r = b;
        endcase
        return r;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sin_val(
        input logic [1:0] q, input logic signed [DATA_WIDTH-1:0] a, b);
        logic signed [DATA_WIDTH-1:0] r;
        case (q)
            2'd0:    r = b;
            2'd1:    r = a;
            2'd2:    r = -b;
            default: r = -a;
        endcase
        return r;
    endfunction

    logic signed [DATA_WIDTH-1:0] rom [N];
    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] LV = lut_entry(k);
        assign rom[k] = LV;
    end

    logic [ACC_WIDTH-1:0] freq_sh_q  [NUM_CH];
    logic [ACC_WIDTH-1:0] phase_sh_q [NUM_CH];
    logic [ACC_WIDTH-1:0] freq_act_q [NUM_CH];
    logic [ACC_WIDTH-1:0] phase_act_q[NUM_CH];
    logic [ACC_WIDTH-1:0] acc_q      [NUM_CH];
    logic [CH_W-1:0]      slot_q, slot_d;

    logic [1:0]                   quad_p0, quad_p1;
    logic [LUT_AW-1:0]            idx_p0;
    logic [CH_W-1:0]              ch_p0, ch_p1;
    logic                         vld_p0, vld_p1;
    logic signed [DATA_WIDTH-1:0] lut_a_p1, lut_b_p1;

    logic [NUM_CH*DATA_WIDTH-1:0] cos_q, sin_q;
    logic                         out_vld_q;
    logic [CH_W-1:0]              out_ch_q;

    logic [ACC_WIDTH-1:0] acc_sel, phase_sel, phase_sum;
    logic                 unused_frac;

    always_comb begin
        slot_d = slot_q;
        if (Sync)
            slot_d = '0;
        else if (Enable)
            slot_d = (slot_q == CH_W'(NUM_CH - 1)) ? '0 : slot_q + CH_W'(1);

        acc_sel   = '0;
        phase_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (slot_q == CH_W'(c)) begin
                acc_sel   = acc_q[c];
                phase_sel = phase_act_q[c];
            end
        end
        // Pre-update accumulator plus offset, wrapping mod 2^ACC_WIDTH.
        phase_sum = acc_sel + phase_sel;
    end

    // Bits below the table index are truncated on purpose.
    assign unused_frac = ^phase_sum[FRAC_LSB-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                freq_sh_q[c]   <= '0;
                phase_sh_q[c]  <= '0;
                freq_act_q[c]  <= '0;
                phase_act_q[c] <= '0;
                acc_q[c]       <= '0;
            end
            slot_q    <= '0;
            quad_p0   <= '0;
            idx_p0    <= '0;
            ch_p0     <= '0;
            vld_p0    <= 1'b0;
            quad_p1   <= '0;
            ch_p1     <= '0;
            vld_p1    <= 1'b0;
            lut_a_p1  <= '0;
            lut_b_p1  <= '0;
            cos_q     <= '0;
            sin_q     <= '0;
            out_vld_q <= 1'b0;
            out_ch_q  <= '0;
        end else begin
            slot_q <= slot_d;
            for (int c = 0; c < NUM_CH; c++) begin
                if (LoadF && ChSel == CH_W'(c)) freq_sh_q[c]  <= FreqPhase;
                if (LoadP && ChSel == CH_W'(c)) phase_sh_q[c] <= FreqPhase;
                // Commit samples the shadows before this edge's loads land.
                if (Commit) begin
                    freq_act_q[c]  <= freq_sh_q[c];
                    phase_act_q[c] <= phase_sh_q[c];
                end
                if (Sync)
                    acc_q[c] <= '0;
                else if (Enable && slot_q == CH_W'(c))
                    acc_q[c] <= acc_q[c] + freq_act_q[c];
            end

            out_vld_q <= 1'b0;
            if (Enable) begin
                // Stage 0: phase of the current slot -> quadrant and index
                quad_p0 <= phase_sum[ACC_WIDTH-1 -: 2];
                idx_p0  <= phase_sum[ACC_WIDTH-3 -: LUT_AW];
                ch_p0   <= slot_q;
                vld_p0  <= 1'b1;
                // Stage 1: dual-port table read
                lut_a_p1 <= rom[idx_p0];
                lut_b_p1 <= rom[~idx_p0];
                quad_p1  <= quad_p0;
                ch_p1    <= ch_p0;
                vld_p1   <= vld_p0;
                // Stage 2: quadrant fold into the channel's output slice
                out_vld_q <= vld_p1;
                if (vld_p1) begin
                    out_ch_q <= ch_p1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (ch_p1 == CH_W'(c)) begin
                            cos_q[c*DATA_WIDTH +: DATA_WIDTH] <= cos_val(quad_p1, lut_a_p1, lut_b_p1);
                            sin_q[c*DATA_WIDTH +: DATA_WIDTH] <= sin_val(quad_p1, lut_a_p1, lut_b_p1);
                        end
                    end
                end
            end
        end
    end

    assign Cos_Out   = cos_q;
    assign Sin_Out   = sin_q;
    assign Out_Valid = out_vld_q;
    assign Out_Ch    = out_ch_q;
    assign io_oeb    = 16'h0000;

endmodule

// File: tb/tb_dds_nco_multich.sv
module tb_dds_nco_multich;

    localparam int DW = 16;
    localparam int AW = 24;
    localparam int NC = 4;
    localparam int CW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             Enable = 1'b0;
    logic             LoadF = 1'b0;
    logic             LoadP = 1'b0;
    logic             Commit = 1'b0;
    logic             Sync = 1'b0;
    logic [CW-1:0]    ChSel = '0;
    logic [AW-1:0]    FreqPhase = '0;
    logic [NC*DW-1:0] Cos_Out, Sin_Out;
    logic             Out_Valid;
    logic [CW-1:0]    Out_Ch;
    logic [15:0]      io_oeb;

    dds_nco_multich #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LUT_AW(8), .NUM_CH(NC), .CH_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .Enable(Enable), .LoadF(LoadF), .LoadP(LoadP),
        .Commit(Commit), .Sync(Sync), .ChSel(ChSel), .FreqPhase(FreqPhase),
        .Cos_Out(Cos_Out), .Sin_Out(Sin_Out), .Out_Valid(Out_Valid),
        .Out_Ch(Out_Ch), .io_oeb(io_oeb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    typedef struct { int ch; int c; int s; } samp_t;
    samp_t sbq[$];

    // Reference model state
    int unsigned m_acc[NC], m_fs[NC], m_ps[NC], m_fa[NC], m_pa[NC];
    int          m_slot = 0;
    logic [NC*DW-1:0] exp_cos_v = '0;
    logic [NC*DW-1:0] exp_sin_v = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lut(input int k);
        real v;
        v = 32767.0 * $cos(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0);
        return $rtoi(v + 0.5);
    endfunction

    function automatic longint cs(input int c);
        return longint'($signed(Cos_Out[c*DW +: DW]));
    endfunction

    function automatic longint ss(input int c);
        return longint'($signed(Sin_Out[c*DW +: DW]));
    endfunction

    // Model of one clock edge using the inputs currently applied.
    task automatic model_step();
        int unsigned p;
        int q, idx, a, b;
        samp_t e;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_acc[c] = 0; m_fs[c] = 0; m_ps[c] = 0; m_fa[c] = 0; m_pa[c] = 0;
            end
            m_slot = 0;
            sbq.delete();
            exp_cos_v = '0;
            exp_sin_v = '0;
            return;
        end
        if (Enable) begin
            p   = (m_acc[m_slot] + m_pa[m_slot]) & 32'h00FF_FFFF;
            q   = int'(p >> 22);
            idx = int'((p >> 14) & 32'hFF);
            a   = lut(idx);
            b   = lut(255 - idx);
            e.ch = m_slot;
            case (q)
                0:       begin e.c =  a; e.s =  b; end
                1:       begin e.c = -b; e.s =  a; end
                2:       begin e.c = -a; e.s = -b; end
                default: begin e.c =  b; e.s = -a; end
            endcase
            sbq.push_back(e);
        end
        if (Sync) begin
            for (int c = 0; c < NC; c++) m_acc[c] = 0;
            m_slot = 0;
        end else if (Enable) begin
            m_acc[m_slot] = (m_acc[m_slot] + m_fa[m_slot]) & 32'h00FF_FFFF;
            m_slot = (m_slot + 1) % NC;
        end
        if (Commit) begin
            for (int c = 0; c < NC; c++) begin
                m_fa[c] = m_fs[c];
                m_pa[c] = m_ps[c];
            end
        end
        if (int'(ChSel) < NC) begin
            if (LoadF) m_fs[ChSel] = FreqPhase;
            if (LoadP) m_ps[ChSel] = FreqPhase;
        end
    endtask

    // Inputs are applied at negedge+1; after tick the edge has happened and
    // the monitor has consumed its output.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_vec(input string name);
        chk({name, "_cos"}, longint'(Cos_Out), longint'(exp_cos_v));
        chk({name, "_sin"}, longint'(Sin_Out), longint'(exp_sin_v));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        samp_t e;
        if (Out_Valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: Out_Valid with ch %0d but nothing expected", Out_Ch);
            end else begin
                e = sbq.pop_front();
                pops++;
                chk("sb_ch", longint'(Out_Ch), longint'(e.ch));
                chk($sformatf("sb_cos_ch%0d", e.ch), cs(e.ch), longint'(e.c));
                chk($sformatf("sb_sin_ch%0d", e.ch), ss(e.ch), longint'(e.s));
                exp_cos_v[e.ch*DW +: DW] = DW'(e.c);
                exp_sin_v[e.ch*DW +: DW] = DW'(e.s);
            end
        end
    end

    initial begin
        @(negedge clk);
        #1;
        run(2);
        chk("rst_cos", longint'(Cos_Out), 0);
        chk("rst_sin", longint'(Sin_Out), 0);
        chk("rst_valid", longint'(Out_Valid), 0);
        chk("rst_ch", longint'(Out_Ch), 0);
        chk("io_oeb", longint'(io_oeb), 0);

        // First Out_Valid three enabled cycles after rst falls
        rst = 1'b0;
        Enable = 1'b1;
        tick(); chk("lat_v1", longint'(Out_Valid), 0);
        tick(); chk("lat_v2", longint'(Out_Valid), 0);
        tick(); chk("lat_v3", longint'(Out_Valid), 1);
        chk("lat_ch", longint'(Out_Ch), 0);
        run(5);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("zero_cos_ch%0d", c), cs(c), 32767);
            chk($sformatf("zero_sin_ch%0d", c), ss(c), 101);
        end

        // Phase offsets
        ChSel = 3'd2; FreqPhase = 24'h800000; LoadP = 1'b1; tick(); LoadP = 1'b0;
        Commit = 1'b1; tick(); Commit = 1'b0;
        run(8);
        chk("ph180_cos_ch2", cs(2), -32767);
        chk("ph180_sin_ch2", ss(2), -101);
        chk("ph180_cos_ch0", cs(0), 32767);
        ChSel = 3'd1; FreqPhase = 24'h400000; LoadP = 1'b1; tick(); LoadP = 1'b0;
        Commit = 1'b1; tick(); Commit = 1'b0;
        run(8);
        chk("ph90_cos_ch1", cs(1), -101);
        chk("ph90_sin_ch1", ss(1), 32767);
        chk_vec("ph90_vec");

        // Load without Commit leaves outputs alone
        ChSel = 3'd0; FreqPhase = 24'h010000; LoadF = 1'b1; tick(); LoadF = 1'b0;
        run(12);
        chk("nocommit_cos_ch0", cs(0), 32767);
        chk_vec("nocommit_vec");

        // Commit together with a Load: ch0's earlier word goes active, ch3 keeps old
        ChSel = 3'd3; FreqPhase = 24'h020000; LoadF = 1'b1; Commit = 1'b1; tick();
        LoadF = 1'b0; Commit = 1'b0;
        run(40);
        chk("samecyc_cos_ch3", cs(3), 32767);
        chk("samecyc_sin_ch3", ss(3), 101);
        Commit = 1'b1; tick(); Commit = 1'b0;
        run(40);

        // Sync realigns; ch0 sweeps one full period in 1024 enabled clocks
        Sync = 1'b1; tick(); Sync = 1'b0;
        run(3);
        chk("sync_ch", longint'(Out_Ch), 0);
        chk("sync_cos_ch0", cs(0), 32767);
        chk("sync_sin_ch0", ss(0), 101);
        run(256);
        chk("q1_ch", longint'(Out_Ch), 0);
        chk("q1_cos_ch0", cs(0), -101);
        chk("q1_sin_ch0", ss(0), 32767);
        run(768);
        chk("wrap_ch", longint'(Out_Ch), 0);
        chk("wrap_cos_ch0", cs(0), 32767);
        chk("wrap_sin_ch0", ss(0), 101);

        // Enable low: hold everything
        Enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", longint'(Out_Valid), 0);
            chk_vec("hold_vec");
        end
        Enable = 1'b1;
        run(12);
        chk_vec("resume_vec");

        // Mid-run reset clears outputs and all shadow/active state
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_cos", longint'(Out_Cos_dummy()), 0);
        chk("mrst_sin", longint'(Sin_Out), 0);
        chk("mrst_valid", longint'(Out_Valid), 0);
        chk("mrst_ch", longint'(Out_Ch), 0);
        ChSel = 3'd5; FreqPhase = 24'h800000; LoadP = 1'b1; tick(); LoadP = 1'b0;
        Commit = 1'b1; tick(); Commit = 1'b0;
        run(12);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("post_cos_ch%0d", c), cs(c), 32767);
            chk($sformatf("post_sin_ch%0d", c), ss(c), 101);
        end
        chk_vec("post_vec");

        chk("sb_pops_seen", longint'(pops > 1000), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [NC*DW-1:0] Out_Cos_dummy();
        return Cos_Out;
    endfunction

endmodule
